// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM-stage memory unit and data memory.
// Stores are lane-aligned on entry and drained in order over a req/ack handshake.
// Loads are checked against pending entries for RAW ordering, and a fence waits
// for the buffer to drain.
// Optional macro STB_FWD_EN: forward a full-word youngest match to the load
// instead of stalling.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_be,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        ld_fwd,
    output logic [31:0] ld_fwd_data,
    input  logic        fence_req,
    output logic        fence_stall,
    output logic        empty,
    output logic        mem_wr_req,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_be,
    input  logic        mem_wr_ack
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    // Move right-justified store data into its byte lane within the word.
    function automatic logic [31:0] align_data(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

    // Shift byte enables to the addressed lane; bits past lane 3 fall off.
    function automatic logic [3:0] align_be(input logic [3:0] be, input logic [1:0] off);
        return be << off;
    endfunction

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [DEPTH-1:0] ent_vld;
    logic [29:0]      ent_word [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_be   [DEPTH];
    logic             enq;
    logic             deq;
    logic [DEPTH-1:0] match;
    logic             unused_ld_off;

    // Byte offset of the load is irrelevant: matching is per word.
    assign unused_ld_off = ^ld_addr[1:0];

    // Full is decided from registered count only; an ack this cycle does not free a slot.
    assign st_ready    = (count != FULL_CNT);
    // Zero byte enables mark a misaligned access: accepted but never written.
    assign enq         = st_valid && st_ready && (st_be != 4'b0000);
    assign mem_wr_req  = (count != '0);
    assign deq         = mem_wr_req && mem_wr_ack;
    assign empty       = (count == '0);
    assign fence_stall = fence_req && !empty;

    // Payload is gated so the bus reads zero whenever nothing is pending.
    assign mem_wr_addr = mem_wr_req ? {ent_word[head], 2'b00} : 32'h0;
    assign mem_wr_data = mem_wr_req ? ent_data[head] : 32'h0;
    assign mem_wr_be   = mem_wr_req ? ent_be[head] : 4'h0;

    // Pointers, occupancy and entry valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (deq) ent_vld[head] <= 1'b0;
            if (enq) ent_vld[tail] <= 1'b1;
        end
    end

    // Entry payload capture; left unreset since ent_vld/count qualify every use.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_word[tail] <= st_addr[31:2];
            ent_data[tail] <= align_data(st_data, st_addr[1:0]);
            ent_be[tail]   <= align_be(st_be, st_addr[1:0]);
        end
    end

    // Word-address compare of the MEM load against every live entry, including one being acked.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = ld_valid && ent_vld[i] && (ent_word[i] == ld_addr[31:2]);
        end
    end

`ifdef STB_FWD_EN
    logic [PTR_W-1:0] yng_idx;
    logic [PTR_W-1:0] idx;
    logic             yng_hit;

    // Walk oldest to youngest so the last hit is the entry closest to tail.
    always_comb begin
        yng_idx = '0;
        yng_hit = 1'b0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (match[idx]) begin
                yng_idx = idx;
                yng_hit = 1'b1;
            end
        end
    end

    // Only a full-word youngest match can supply the load; partial matches stall.
    assign ld_fwd      = yng_hit && (ent_be[yng_idx] == 4'b1111);
    assign ld_stall    = yng_hit && !ld_fwd;
    assign ld_fwd_data = ld_fwd ? ent_data[yng_idx] : 32'h0;
`else
    assign ld_stall    = |match;
    assign ld_fwd      = 1'b0;
    assign ld_fwd_data = 32'h0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer. Expected memory writes are
// queued as stores are accepted and popped by a write monitor.
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        ld_fwd;
    logic [31:0] ld_fwd_data;
    logic        fence_req;
    logic        fence_stall;
    logic        empty;
    logic        mem_wr_req;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic        mem_wr_ack;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t sb_q[$];
    wr_t mon_exp;
    int  tests = 0;
    int  fails = 0;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .ld_fwd(ld_fwd), .ld_fwd_data(ld_fwd_data),
        .fence_req(fence_req), .fence_stall(fence_stall), .empty(empty),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_be(mem_wr_be), .mem_wr_ack(mem_wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Write monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (mem_wr_req === 1'b1 && mem_wr_ack === 1'b1) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got addr=%h data=%h be=%b, required no write",
                         mem_wr_addr, mem_wr_data, mem_wr_be);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({mem_wr_addr, mem_wr_data, mem_wr_be} !== mon_exp) begin
                    fails++;
                    $display("FAIL wr_payload: got addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                             mem_wr_addr, mem_wr_data, mem_wr_be, mon_exp.addr, mon_exp.data, mon_exp.be);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one store, wait (bounded) until accepted, record the expected write.
    task automatic send_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        int   w;
        wr_t  e;
        logic [3:0] be_al;
        st_valid = 1'b1; st_addr = a; st_data = d; st_be = b;
        w = 0;
        while (st_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        tests++;
        if (st_ready !== 1'b1) begin
            fails++;
            $display("FAIL st_accept_timeout: st_ready=%b after %0d cycles, required 1", st_ready, w);
        end
        be_al = b << a[1:0];
        e.addr = {a[31:2], 2'b00};
        e.data = d << (8 * a[1:0]);
        e.be   = be_al;
        if (b != 4'b0000) sb_q.push_back(e);
        tick();
        st_valid = 1'b0; st_be = 4'b0000;
    endtask

    task automatic wait_empty(input int bound, output int cycles);
        cycles = 0;
        while (empty !== 1'b1 && cycles < bound) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({st_ready, empty, mem_wr_req, ld_stall, ld_fwd, fence_stall} !== 6'b110000) begin
            fails++;
            $display("FAIL reset_flags: got rdy/emp/req/lst/fwd/fst=%b, required 110000",
                     {st_ready, empty, mem_wr_req, ld_stall, ld_fwd, fence_stall});
        end
        tests++;
        if ({mem_wr_addr, mem_wr_data, mem_wr_be, ld_fwd_data} !== '0) begin
            fails++;
            $display("FAIL reset_payload: got addr=%h data=%h be=%b fwd=%h, required all 0",
                     mem_wr_addr, mem_wr_data, mem_wr_be, ld_fwd_data);
        end
    endtask

    task automatic test_align();
        int n;
        mem_wr_ack = 1'b1;
        send_store(32'h103, 32'h0000_00AB, 4'b0001);
        tests++;
        if ({mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_be} !== {1'b1, 32'h100, 32'hAB00_0000, 4'b1000}) begin
            fails++;
            $display("FAIL align_sb: got req=%b addr=%h data=%h be=%b, required 1 00000100 ab000000 1000",
                     mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_be);
        end
        tick();
        tests++;
        if (empty !== 1'b1) begin
            fails++;
            $display("FAIL align_empty: got empty=%b, required 1", empty);
        end
        send_store(32'h502, 32'h0000_BEEF, 4'b0011);
        wait_empty(10, n);
        mem_wr_ack = 1'b0;
    endtask

    task automatic test_full();
        int n;
        mem_wr_ack = 1'b0;
        for (int i = 0; i < 4; i++) send_store(32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111);
        tests++;
        if (st_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_ready: got st_ready=%b, required 0", st_ready);
        end
        st_valid = 1'b1; st_addr = 32'h210; st_data = 32'hA000_0004; st_be = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (st_ready !== 1'b0 || mem_wr_addr !== 32'h200) begin
                fails++;
                $display("FAIL full_hold: got st_ready=%b head_addr=%h, required 0 00000200",
                         st_ready, mem_wr_addr);
            end
        end
        mem_wr_ack = 1'b1;
        tick();
        tests++;
        if (st_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_reopen: got st_ready=%b after first ack, required 1", st_ready);
        end
        sb_q.push_back('{addr: 32'h210, data: 32'hA000_0004, be: 4'b1111});
        tick();
        st_valid = 1'b0; st_be = 4'b0000;
        wait_empty(20, n);
        tests++;
        if (n + 2 != 5) begin
            fails++;
            $display("FAIL full_rate: got %0d cycles to drain 5 writes, required 5", n + 2);
        end
        mem_wr_ack = 1'b0;
    endtask

    task automatic test_drop();
        mem_wr_ack = 1'b1;
        st_valid = 1'b1; st_addr = 32'h301; st_data = 32'h1234_5678; st_be = 4'b0000;
        tests++;
        if (st_ready !== 1'b1) begin
            fails++;
            $display("FAIL drop_ready: got st_ready=%b, required 1", st_ready);
        end
        tick();
        st_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (empty !== 1'b1 || mem_wr_req !== 1'b0 || st_ready !== 1'b1) begin
                fails++;
                $display("FAIL drop_state: got empty=%b req=%b rdy=%b, required 1 0 1",
                         empty, mem_wr_req, st_ready);
            end
            tick();
        end
        mem_wr_ack = 1'b0;
    endtask

    task automatic test_raw();
        int n;
        mem_wr_ack = 1'b0;
        send_store(32'h400, 32'hCAFE_F00D, 4'b1111);
        ld_valid = 1'b1; ld_addr = 32'h402;
        #1;
        tests++;
`ifdef STB_FWD_EN
        if ({ld_stall, ld_fwd, ld_fwd_data} !== {1'b0, 1'b1, 32'hCAFE_F00D}) begin
            fails++;
            $display("FAIL raw_fwd: got stall=%b fwd=%b data=%h, required 0 1 cafef00d",
                     ld_stall, ld_fwd, ld_fwd_data);
        end
`else
        if ({ld_stall, ld_fwd, ld_fwd_data} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL raw_stall: got stall=%b fwd=%b data=%h, required 1 0 00000000",
                     ld_stall, ld_fwd, ld_fwd_data);
        end
`endif
        mem_wr_ack = 1'b1;
        #1;
        tests++;
`ifdef STB_FWD_EN
        if (ld_fwd !== 1'b1 || ld_stall !== 1'b0) begin
`else
        if (ld_stall !== 1'b1 || ld_fwd !== 1'b0) begin
`endif
            fails++;
            $display("FAIL raw_ack_cycle: got stall=%b fwd=%b during ack, required match kept", ld_stall, ld_fwd);
        end
        tick();
        mem_wr_ack = 1'b0;
        tests++;
        if (ld_stall !== 1'b0 || ld_fwd !== 1'b0) begin
            fails++;
            $display("FAIL raw_release: got stall=%b fwd=%b after drain, required 0 0", ld_stall, ld_fwd);
        end
        ld_valid = 1'b0;
        send_store(32'h400, 32'h1122_3344, 4'b1111);
        send_store(32'h401, 32'h0000_005A, 4'b0001);
        ld_valid = 1'b1; ld_addr = 32'h400;
        #1;
        tests++;
        if (ld_stall !== 1'b1 || ld_fwd !== 1'b0) begin
            fails++;
            $display("FAIL raw_partial: got stall=%b fwd=%b, required 1 0", ld_stall, ld_fwd);
        end
        ld_addr = 32'h404;
        #1;
        tests++;
        if (ld_stall !== 1'b0 || ld_fwd !== 1'b0) begin
            fails++;
            $display("FAIL raw_nomatch: got stall=%b fwd=%b, required 0 0", ld_stall, ld_fwd);
        end
        ld_valid = 1'b0;
        mem_wr_ack = 1'b1;
        wait_empty(10, n);
        mem_wr_ack = 1'b0;
    endtask

    task automatic test_fence();
        int n;
        mem_wr_ack = 1'b0;
        send_store(32'h600, 32'h0000_0001, 4'b1111);
        send_store(32'h604, 32'h0000_0002, 4'b1111);
        fence_req = 1'b1;
        #1;
        tests++;
        if (fence_stall !== 1'b1) begin
            fails++;
            $display("FAIL fence_pending: got fence_stall=%b, required 1", fence_stall);
        end
        mem_wr_ack = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (fence_stall === 1'b1) n++;
            tick();
        end
        tests++;
        if (n != 2) begin
            fails++;
            $display("FAIL fence_cycles: got %0d stall cycles, required 2", n);
        end
        tests++;
        if (fence_stall !== 1'b0) begin
            fails++;
            $display("FAIL fence_done: got fence_stall=%b, required 0", fence_stall);
        end
        fence_req = 1'b0;
        mem_wr_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_wr_ack = 1'b0;
        for (int i = 0; i < 3; i++) send_store(32'h700 + 32'(4 * i), 32'h7000_0000 + 32'(i), 4'b1111);
        tests++;
        if (mem_wr_req !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre: got req=%b, required 1", mem_wr_req);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({mem_wr_req, empty, st_ready} !== 3'b011) begin
            fails++;
            $display("FAIL rstmid_async: got req/empty/rdy=%b, required 011", {mem_wr_req, empty, st_ready});
        end
        sb_q.delete();
        tick();
        rst = 1'b0;
        mem_wr_ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (mem_wr_req !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_after: got req=%b empty=%b, required 0 1", mem_wr_req, empty);
        end
        mem_wr_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        ld_valid = 1'b0; ld_addr = '0;
        fence_req = 1'b0; mem_wr_ack = 1'b0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_align();
        test_full();
        test_drop();
        test_raw();
        test_fence();
        test_reset_mid();
        tick();
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d writes never seen, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
